// File: rtl/sum_accumulator.sv
// Registered consumer for the combinational adder: sums COUNT signed samples
// into a widened accumulator and presents each total on a held valid/ready output.
module sum_accumulator #(
    parameter int N     = 5,
    parameter int COUNT = 4,
    parameter int ACC_W = N + $clog2(COUNT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [N-1:0]             sum_in,
    input  logic                     sum_valid,
    output logic                     sum_ready,
    output logic [ACC_W-1:0]         acc_out,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [$clog2(COUNT):0]   sample_cnt
);

    localparam int              CW   = $clog2(COUNT) + 1;
    localparam logic [CW-1:0]   LAST = CW'(COUNT - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_sx;
    logic [ACC_W-1:0] acc_next;
    logic             accept;

    // ACC_W - N >= 1 because COUNT >= 2, so the replication is never empty.
    assign sum_sx   = {{(ACC_W-N){sum_in[N-1]}}, sum_in};
    assign acc_next = acc + sum_sx;
    assign accept   = sum_valid & sum_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ACCUM;
            acc        <= '0;
            acc_out    <= '0;
            sample_cnt <= '0;
            acc_valid  <= 1'b0;
            sum_ready  <= 1'b1;
        end else if (clear) begin
            // Abort: like reset, but the last result stays on acc_out.
            state      <= ACCUM;
            acc        <= '0;
            sample_cnt <= '0;
            acc_valid  <= 1'b0;
            sum_ready  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (sample_cnt == LAST) begin
                            acc_out    <= acc_next;
                            acc        <= '0;
                            sample_cnt <= '0;
                            state      <= HOLD;
                            acc_valid  <= 1'b1;
                            sum_ready  <= 1'b0;
                        end else begin
                            acc        <= acc_next;
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Release costs one bubble: input reopens the cycle after.
                    if (acc_ready) begin
                        state     <= ACCUM;
                        acc_valid <= 1'b0;
                        sum_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    acc_valid <= 1'b0;
                    sum_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with a group-sum scoreboard.
module tb_sum_accumulator;

    localparam int N     = 5;
    localparam int COUNT = 4;
    localparam int ACC_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic [N-1:0]     sum_in;
    logic             sum_valid;
    logic             sum_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic [2:0]       sample_cnt;

    sum_accumulator #(.N(N), .COUNT(COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Bench-side model of the group in progress.
    int               m_acc  = 0;
    int               m_cnt  = 0;
    bit               m_hold = 1'b0;
    logic [ACC_W-1:0] q[$];
    logic [ACC_W-1:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int sx5(input logic [N-1:0] v);
        return v[N-1] ? int'(v) - 32 : int'(v);
    endfunction

    task automatic model_reset();
        m_acc  = 0;
        m_cnt  = 0;
        m_hold = 1'b0;
    endtask

    // One clock with the given input; model tracks whether it is accepted.
    task automatic drive(input logic v, input logic [N-1:0] d);
        logic [31:0] t;
        sum_valid = v;
        sum_in    = d;
        @(posedge clk);
        if (v && !m_hold) begin
            m_acc += sx5(d);
            if (m_cnt == COUNT - 1) begin
                t = m_acc;
                q.push_back(t[ACC_W-1:0]);
                m_acc  = 0;
                m_cnt  = 0;
                m_hold = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        #1;
        sum_valid = 1'b0;
    endtask

    task automatic group4(input logic [N-1:0] a, b, c, d);
        drive(1'b1, a);
        drive(1'b1, b);
        drive(1'b1, c);
        drive(1'b1, d);
    endtask

    // Wait (bounded) for acc_valid, then score it against the queue head.
    task automatic wait_result(input string tag);
        int n = 0;
        @(negedge clk);
        while (!acc_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 0);
        chk({tag, "_valid"}, {31'b0, acc_valid}, 1);
        if (q.size() == 0) begin
            chk({tag, "_queue"}, q.size(), 1);
            held = 'x;
        end else begin
            held = q.pop_front();
            chk({tag, "_acc_out"}, {25'b0, acc_out}, {25'b0, held});
        end
        chk({tag, "_ready_low"}, {31'b0, sum_ready}, 0);
        chk({tag, "_cnt0"}, {29'b0, sample_cnt}, 0);
    endtask

    task automatic release_result(input string tag);
        acc_ready = 1'b1;
        @(posedge clk);
        m_hold = 1'b0;
        #1;
        acc_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_ready"}, {31'b0, sum_ready}, 1);
        chk({tag, "_rel_valid"}, {31'b0, acc_valid}, 0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; sum_in = '0; sum_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, sum_ready}, 1);
        chk("rst_valid", {31'b0, acc_valid}, 0);
        chk("rst_acc_out", {25'b0, acc_out}, 0);
        chk("rst_cnt", {29'b0, sample_cnt}, 0);

        // Basic mixed-sign group: -16 -2 15 1 = -2
        group4(5'h10, 5'h1E, 5'h0F, 5'h01);
        wait_result("basic");
        chk("basic_const", {25'b0, acc_out}, 32'h7E);
        release_result("basic");

        group4(5'h0F, 5'h0F, 5'h0F, 5'h0F);
        wait_result("posmax");
        chk("posmax_const", {25'b0, acc_out}, 32'h3C);
        release_result("posmax");

        group4(5'h10, 5'h10, 5'h10, 5'h10);
        wait_result("negmax");
        chk("negmax_const", {25'b0, acc_out}, 32'h40);
        release_result("negmax");

        // Gaps: valid pattern 1,0,0,1,1,0,1
        drive(1'b1, 5'h03);
        drive(1'b0, 5'h1F);
        drive(1'b0, 5'h1F);
        @(negedge clk);
        chk("gap_cnt1", {29'b0, sample_cnt}, 1);
        drive(1'b1, 5'h1C);
        drive(1'b1, 5'h07);
        drive(1'b0, 5'h0A);
        @(negedge clk);
        chk("gap_cnt3", {29'b0, sample_cnt}, 3);
        drive(1'b1, 5'h0B);
        wait_result("gap");

        // Backpressure: held result stable, offered samples ignored
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'h07);
            @(negedge clk);
            chk("bp_valid", {31'b0, acc_valid}, 1);
            chk("bp_ready", {31'b0, sum_ready}, 0);
            chk("bp_acc_out", {25'b0, acc_out}, {25'b0, held});
        end
        release_result("bp");
        chk("bp_cnt", {29'b0, sample_cnt}, 0);

        // Clear mid-group drops partial sum and the sample offered with it
        drive(1'b1, 5'h05);
        drive(1'b1, 5'h03);
        @(negedge clk);
        chk("clr_cnt2", {29'b0, sample_cnt}, 2);
        clear = 1'b1; sum_valid = 1'b1; sum_in = 5'h07;
        @(posedge clk);
        model_reset();
        #1 clear = 1'b0; sum_valid = 1'b0;
        @(negedge clk);
        chk("clr_cnt0", {29'b0, sample_cnt}, 0);
        chk("clr_ready", {31'b0, sum_ready}, 1);
        group4(5'h02, 5'h02, 5'h02, 5'h02);
        wait_result("clr");
        chk("clr_const", {25'b0, acc_out}, 32'h08);
        release_result("clr");

        // Clear while holding: result discarded, acc_out kept
        group4(5'h01, 5'h01, 5'h01, 5'h01);
        wait_result("clrhold");
        clear = 1'b1;
        @(posedge clk);
        model_reset();
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clrhold_valid", {31'b0, acc_valid}, 0);
        chk("clrhold_ready", {31'b0, sum_ready}, 1);
        chk("clrhold_keep", {25'b0, acc_out}, 32'h04);

        // Reset while holding
        group4(5'h0F, 5'h0F, 5'h0F, 5'h0F);
        wait_result("rsthold");
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rsthold_acc_out", {25'b0, acc_out}, 0);
        chk("rsthold_valid", {31'b0, acc_valid}, 0);
        chk("rsthold_cnt", {29'b0, sample_cnt}, 0);
        chk("rsthold_ready", {31'b0, sum_ready}, 1);

        // Reset wins over clear: acc_out returns to 0
        group4(5'h03, 5'h03, 5'h03, 5'h03);
        wait_result("prio");
        release_result("prio");
        chk("prio_before", {25'b0, acc_out}, 32'h0C);
        rst_n = 1'b0; clear = 1'b1;
        @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1; clear = 1'b0;
        @(negedge clk);
        chk("prio_acc_out", {25'b0, acc_out}, 0);
        chk("prio_ready", {31'b0, sum_ready}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
